// File: rtl/wb_pkg.sv
// Shared widths and the load-FIFO entry type for the register-file write-back path.
// Used by both builds; WB_BYPASS_EN only changes port lists in wb_fifo and reg_wb_ctrl.
package wb_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          live;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wb_entry_t;

  function automatic logic entry_hit(input wb_entry_t e, input logic [AW-1:0] addr);
    return e.live && (e.dst == addr);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular load buffer with per-entry live bits, kill-by-dst and two dst lookup ports.
// Youngest-match data outputs exist only when WB_BYPASS_EN is defined.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_dst_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  logic [AW-1:0] kill_dst_i,
  output wb_entry_t     head_o,
  output logic          empty_o,
  output logic          full_o,
  input  logic [AW-1:0] lk1_dst_i,
  input  logic [AW-1:0] lk2_dst_i,
  output logic          lk1_hit_o,
  output logic          lk2_hit_o
`ifdef WB_BYPASS_EN
  ,
  output logic [DW-1:0] lk1_data_o,
  output logic [DW-1:0] lk2_data_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Popped slots are cleared so every live bit lies inside the occupied window.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && entry_hit(mem_q[i], kill_dst_i)) mem_d[i].live = 1'b0;
    end
    if (pop_i) begin
      mem_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d             = rd_ptr_q + 1'b1;
      cnt_d                = cnt_d - 1'b1;
    end
    if (push_i) begin
      mem_d[wr_ptr_q] = '{live: 1'b1, dst: push_dst_i, data: push_data_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      cnt_d           = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FullCnt);

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    lk1_hit_o = 1'b0;
    lk2_hit_o = 1'b0;
`ifdef WB_BYPASS_EN
    lk1_data_o = '0;
    lk2_data_o = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (entry_hit(mem_q[idx], lk1_dst_i)) begin
        lk1_hit_o = 1'b1;
`ifdef WB_BYPASS_EN
        lk1_data_o = mem_q[idx].data;
`endif
      end
      if (entry_hit(mem_q[idx], lk2_dst_i)) begin
        lk2_hit_o = 1'b1;
`ifdef WB_BYPASS_EN
        lk2_data_o = mem_q[idx].data;
`endif
      end
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: ALU-priority arbitration of one register-file write port, load FIFO,
// r0 filtering and pending-write reporting. WB_BYPASS_EN adds the fwd1/fwd2 forwarding ports.
module reg_wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dst,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_dst,
  input  logic [DW-1:0] ld_data,
  output logic          write_reg,
  output logic [AW-1:0] write1,
  output logic [DW-1:0] write_data,
  input  logic [AW-1:0] read1,
  input  logic [AW-1:0] read2,
  output logic          pend1,
  output logic          pend2
`ifdef WB_BYPASS_EN
  ,
  output logic          fwd1_valid,
  output logic          fwd2_valid,
  output logic [DW-1:0] fwd1_data,
  output logic [DW-1:0] fwd2_data
`endif
);

  wb_entry_t     head;
  logic          fifo_empty, fifo_full;
  logic          hit1, hit2;
  logic          alu_issue, ld_push, pop;
  logic          slot_hit1, slot_hit2;
  logic          write_reg_q, write_reg_d;
  logic [AW-1:0] write1_q, write1_d;
  logic [DW-1:0] write_data_q, write_data_d;
`ifdef WB_BYPASS_EN
  logic [DW-1:0] lk1_data, lk2_data;
`endif

  assign ld_ready  = !rst && !fifo_full;
  assign alu_issue = alu_valid && (alu_dst != '0);
  assign ld_push   = ld_valid && ld_ready && (ld_dst != '0);
  assign pop       = !alu_issue && !fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ld_push),
    .push_dst_i  (ld_dst),
    .push_data_i (ld_data),
    .pop_i       (pop),
    .kill_i      (alu_issue),
    .kill_dst_i  (alu_dst),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .lk1_dst_i   (read1),
    .lk2_dst_i   (read2),
    .lk1_hit_o   (hit1),
    .lk2_hit_o   (hit2)
`ifdef WB_BYPASS_EN
    ,
    .lk1_data_o  (lk1_data),
    .lk2_data_o  (lk2_data)
`endif
  );

  // A dead head is still popped; it just leaves the slot idle.
  always_comb begin
    write_reg_d  = 1'b0;
    write1_d     = write1_q;
    write_data_d = write_data_q;
    if (alu_issue) begin
      write_reg_d  = 1'b1;
      write1_d     = alu_dst;
      write_data_d = alu_data;
    end else if (pop && head.live) begin
      write_reg_d  = 1'b1;
      write1_d     = head.dst;
      write_data_d = head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg_q  <= 1'b0;
      write1_q     <= '0;
      write_data_q <= '0;
    end else begin
      write_reg_q  <= write_reg_d;
      write1_q     <= write1_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_reg  = write_reg_q;
  assign write1     = write1_q;
  assign write_data = write_data_q;

  assign slot_hit1 = write_reg_q && (write1_q == read1);
  assign slot_hit2 = write_reg_q && (write1_q == read2);
  assign pend1     = (read1 != '0) && (hit1 || slot_hit1);
  assign pend2     = (read2 != '0) && (hit2 || slot_hit2);

`ifdef WB_BYPASS_EN
  // FIFO entries are younger than the slot, so they take priority.
  assign fwd1_valid = pend1;
  assign fwd2_valid = pend2;
  assign fwd1_data  = !pend1 ? '0 : hit1 ? lk1_data : write_data_q;
  assign fwd2_data  = !pend2 ? '0 : hit2 ? lk2_data : write_data_q;
`endif

endmodule
